// File: rtl/nco_pkg.sv
// nco_pkg: definitions shared by the NCO configuration path.
//   FREQ_W / DUTY_W  default tuning-word and duty-word widths
//   wave_t           2-bit waveform encodings
//   ctrl_byte_t      layout of the I2C control byte
//   sched_state_t    scheduler states
package nco_pkg;

    localparam int FREQ_W = 64;
    localparam int DUTY_W = 16;

    typedef enum logic [1:0] {
        WAVE_SINE     = 2'd0,
        WAVE_SQUARE   = 2'd1,
        WAVE_TRIANGLE = 2'd2,
        WAVE_SAW      = 2'd3
    } wave_t;

    // I2C control byte, MSB first: the field order fixes the bit positions
    // (enable = bit 0, wave = bits 2:1, duty select = bit 3, freq select = bit 4).
    typedef struct packed {
        logic [2:0] reserved;
        logic       freq_sel;
        logic       duty_sel;
        logic [1:0] wave;
        logic       enable;
    } ctrl_byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RAMP  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/nco_cfg_scheduler_if.sv
// nco_cfg_scheduler_if: configuration bus from the I2C slave to the scheduler.
//   cfg_busy        transaction in progress; falling edge = transaction complete
//   cfg_error       ack error seen; a transaction ending with this set is dropped
//   cfg_enable      requested NCO enable
//   cfg_wave        requested waveform select
//   cfg_frequency   requested tuning word
//   cfg_duty_cycle  requested duty word
// master = I2C slave side (drives), slave = scheduler side (samples).
interface nco_cfg_scheduler_if #(
    parameter int FREQ_W = nco_pkg::FREQ_W,
    parameter int DUTY_W = nco_pkg::DUTY_W
);
    logic              cfg_busy;
    logic              cfg_error;
    logic              cfg_enable;
    logic [1:0]        cfg_wave;
    logic [FREQ_W-1:0] cfg_frequency;
    logic [DUTY_W-1:0] cfg_duty_cycle;

    modport master (
        output cfg_busy, cfg_error, cfg_enable, cfg_wave, cfg_frequency, cfg_duty_cycle
    );

    modport slave (
        input cfg_busy, cfg_error, cfg_enable, cfg_wave, cfg_frequency, cfg_duty_cycle
    );
endinterface

// File: rtl/nco_freq_ramp.sv
// nco_freq_ramp: one geometric glide step of the tuning word.
//   current  tuning word presently applied
//   target   tuning word being glided toward
//   next     value to apply at the next tick
//   reached  next equals target
// step = (target - current) >>> RAMP_SHIFT, computed one bit wider so the
// difference keeps its sign; a zero step snaps straight onto the target.
module nco_freq_ramp #(
    parameter int FREQ_W     = 64,
    parameter int RAMP_SHIFT = 4
) (
    input  logic [FREQ_W-1:0] current,
    input  logic [FREQ_W-1:0] target,
    output logic [FREQ_W-1:0] next,
    output logic              reached
);
    logic signed [FREQ_W:0] diff;
    logic signed [FREQ_W:0] step;
    logic signed [FREQ_W:0] next_wide;

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (here unconditionally first), otherwise synthesis infers a latch.
    always_comb begin
        diff = $signed({1'b0, target}) - $signed({1'b0, current});
        step = diff >>> RAMP_SHIFT;
        next_wide = $signed({1'b0, current}) + step;
        if (step == '0) begin
            next_wide = $signed({1'b0, target});
        end
    end

    // The arithmetic shift floors toward minus infinity, so |step| <= |diff|:
    // the glide can neither overshoot nor leave the 0..2^FREQ_W-1 range.
    assign next    = next_wide[FREQ_W-1:0];
    assign reached = (next_wide == $signed({1'b0, target}));

endmodule

// File: rtl/nco_cfg_scheduler.sv
// nco_cfg_scheduler: applies captured configuration to the NCO glitch-free.
//   clk, reset_n     clock, asynchronous active-low reset
//   cfg              configuration bus (slave modport)
//   phase_wrap       one-cycle pulse from the NCO on accumulator overflow
//   nco_enable       applied enable
//   nco_wave         applied waveform
//   nco_frequency    applied (gliding) tuning word
//   nco_duty_cycle   applied duty
//   sched_busy       an update is pending (ARMED or RAMP)
//   update_done      one-cycle pulse when the tuning word reaches its target
//   timeout_seen     sticky: a synthetic wrap was used; cleared by next capture
// Enable/wave/duty change only on a tick (phase wrap or timeout); the tuning
// word glides one geometric step per tick toward the captured target.
module nco_cfg_scheduler #(
    parameter int              FREQ_W       = nco_pkg::FREQ_W,
    parameter int              DUTY_W       = nco_pkg::DUTY_W,
    parameter int              RAMP_SHIFT   = 4,
    parameter int              WRAP_TIMEOUT = 65536,
    parameter logic [DUTY_W-1:0] DUTY_RESET = DUTY_W'(16'h8000)
) (
    input  logic               clk,
    input  logic               reset_n,
    nco_cfg_scheduler_if.slave cfg,
    input  logic               phase_wrap,
    output logic               nco_enable,
    output logic [1:0]         nco_wave,
    output logic [FREQ_W-1:0]  nco_frequency,
    output logic [DUTY_W-1:0]  nco_duty_cycle,
    output logic               sched_busy,
    output logic               update_done,
    output logic               timeout_seen
);
    import nco_pkg::*;

    localparam int              CNT_W    = $clog2(WRAP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRAP_TIMEOUT - 1);

    sched_state_t      state;
    logic              busy_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              sh_enable;
    logic [1:0]        sh_wave;
    logic [FREQ_W-1:0] sh_frequency;
    logic [DUTY_W-1:0] sh_duty_cycle;

    logic              active;
    logic              capture;
    logic              synth_tick;
    logic              tick;
    logic [FREQ_W-1:0] ramp_next;
    logic              ramp_reached;

    assign active     = (state != IDLE);
    assign capture    = busy_q & ~cfg.cfg_busy & ~cfg.cfg_error;
    assign synth_tick = active && (tmo_cnt == CNT_LAST);
    assign tick       = phase_wrap | synth_tick;
    assign sched_busy = active;

    nco_freq_ramp #(
        .FREQ_W     (FREQ_W),
        .RAMP_SHIFT (RAMP_SHIFT)
    ) u_ramp (
        .current (nco_frequency),
        .target  (sh_frequency),
        .next    (ramp_next),
        .reached (ramp_reached)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            busy_q         <= 1'b0;
            tmo_cnt        <= '0;
            sh_enable      <= 1'b0;
            sh_wave        <= 2'd0;
            sh_frequency   <= '0;
            sh_duty_cycle  <= '0;
            nco_enable     <= 1'b0;
            nco_wave       <= 2'd0;
            nco_frequency  <= '0;
            nco_duty_cycle <= DUTY_RESET;
            update_done    <= 1'b0;
            timeout_seen   <= 1'b0;
        end else begin
            busy_q      <= cfg.cfg_busy;
            update_done <= 1'b0;

            if (capture) begin
                // A capture takes priority; a tick in the same cycle is dropped.
                sh_enable     <= cfg.cfg_enable;
                sh_wave       <= cfg.cfg_wave;
                sh_frequency  <= cfg.cfg_frequency;
                sh_duty_cycle <= cfg.cfg_duty_cycle;
                timeout_seen  <= 1'b0;
                tmo_cnt       <= '0;
                state         <= ARMED;
            end else begin
                if (!active || tick) begin
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end

                if (active && tick) begin
                    if (synth_tick && !phase_wrap) begin
                        timeout_seen <= 1'b1;
                    end
                    if (state == ARMED) begin
                        nco_enable     <= sh_enable;
                        nco_wave       <= sh_wave;
                        nco_duty_cycle <= sh_duty_cycle;
                    end
                    nco_frequency <= ramp_next;
                    if (ramp_reached) begin
                        update_done <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state       <= RAMP;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nco_cfg_scheduler.sv
// tb_nco_cfg_scheduler: scoreboard bench for nco_cfg_scheduler.
// dut0: RAMP_SHIFT=0, WRAP_TIMEOUT=8  (direct jumps, short timeout)
// dut2: RAMP_SHIFT=2, WRAP_TIMEOUT=64 (geometric glide)
// Expected output snapshots are queued with the cycle they are due in and
// compared on the falling edge of that cycle.
module tb_nco_cfg_scheduler;

    localparam int FW = 64;
    localparam int DW = 16;

    typedef struct {
        int          due;
        logic        en;
        logic [1:0]  wave;
        logic [63:0] freq;
        logic [15:0] duty;
        logic        done;
        logic        busy;
        logic        ts;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    exp_t q0[$];
    exp_t q2[$];

    nco_cfg_scheduler_if #(.FREQ_W(FW), .DUTY_W(DW)) cfg0 ();
    nco_cfg_scheduler_if #(.FREQ_W(FW), .DUTY_W(DW)) cfg2 ();

    logic          pw0, en0, done0, busy0, ts0;
    logic [1:0]    wave0;
    logic [FW-1:0] freq0;
    logic [DW-1:0] duty0;
    logic          pw2, en2, done2, busy2, ts2;
    logic [1:0]    wave2;
    logic [FW-1:0] freq2;
    logic [DW-1:0] duty2;

    nco_cfg_scheduler #(
        .FREQ_W(FW), .DUTY_W(DW), .RAMP_SHIFT(0), .WRAP_TIMEOUT(8), .DUTY_RESET(16'h8000)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .cfg(cfg0), .phase_wrap(pw0),
        .nco_enable(en0), .nco_wave(wave0), .nco_frequency(freq0), .nco_duty_cycle(duty0),
        .sched_busy(busy0), .update_done(done0), .timeout_seen(ts0)
    );

    nco_cfg_scheduler #(
        .FREQ_W(FW), .DUTY_W(DW), .RAMP_SHIFT(2), .WRAP_TIMEOUT(64), .DUTY_RESET(16'h8000)
    ) dut2 (
        .clk(clk), .reset_n(reset_n), .cfg(cfg2), .phase_wrap(pw2),
        .nco_enable(en2), .nco_wave(wave2), .nco_frequency(freq2), .nco_duty_cycle(duty2),
        .sched_busy(busy2), .update_done(done2), .timeout_seen(ts2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic compare(input string who, input exp_t e, input logic en, input logic [1:0] wave,
                           input logic [63:0] freq, input logic [15:0] duty, input logic done,
                           input logic busy, input logic ts);
        string p;
        p = $sformatf("%s@%0d", who, e.due);
        if (e.due != cyc) begin
            check_eq({p, ".late"}, 64'(cyc), 64'(e.due));
        end else begin
            check_eq({p, ".enable"}, 64'(en), 64'(e.en));
            check_eq({p, ".wave"}, 64'(wave), 64'(e.wave));
            check_eq({p, ".freq"}, freq, e.freq);
            check_eq({p, ".duty"}, 64'(duty), 64'(e.duty));
            check_eq({p, ".update_done"}, 64'(done), 64'(e.done));
            check_eq({p, ".sched_busy"}, 64'(busy), 64'(e.busy));
            check_eq({p, ".timeout_seen"}, 64'(ts), 64'(e.ts));
        end
    endtask

    exp_t m0, m2;

    always @(negedge clk) begin
        while (q0.size() > 0 && q0[0].due <= cyc) begin
            m0 = q0.pop_front();
            compare("dut0", m0, en0, wave0, freq0, duty0, done0, busy0, ts0);
        end
    end

    always @(negedge clk) begin
        while (q2.size() > 0 && q2[0].due <= cyc) begin
            m2 = q2.pop_front();
            compare("dut2", m2, en2, wave2, freq2, duty2, done2, busy2, ts2);
        end
    end

    task automatic push_exp(input int d, input int due, input logic en, input logic [1:0] wave,
                            input logic [63:0] freq, input logic [15:0] duty, input logic done,
                            input logic busy, input logic ts);
        exp_t e;
        e.due = due; e.en = en; e.wave = wave; e.freq = freq;
        e.duty = duty; e.done = done; e.busy = busy; e.ts = ts;
        if (d == 0) q0.push_back(e);
        else        q2.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_wrap(input int d, input logic v);
        if (d == 0) pw0 = v;
        else        pw2 = v;
    endtask

    task automatic set_cfg(input int d, input logic busy, input logic err, input logic en,
                           input logic [1:0] wave, input logic [63:0] freq, input logic [15:0] duty);
        if (d == 0) begin
            cfg0.cfg_busy = busy; cfg0.cfg_error = err; cfg0.cfg_enable = en;
            cfg0.cfg_wave = wave; cfg0.cfg_frequency = freq; cfg0.cfg_duty_cycle = duty;
        end else begin
            cfg2.cfg_busy = busy; cfg2.cfg_error = err; cfg2.cfg_enable = en;
            cfg2.cfg_wave = wave; cfg2.cfg_frequency = freq; cfg2.cfg_duty_cycle = duty;
        end
    endtask

    // One I2C transaction; returns just after the edge on which it completes.
    // with_wrap raises phase_wrap so it lands on that same edge.
    task automatic capture(input int d, input logic err, input logic en, input logic [1:0] wave,
                           input logic [63:0] freq, input logic [15:0] duty, input logic with_wrap);
        idle(1);
        set_cfg(d, 1'b1, err, en, wave, freq, duty);
        idle(1);
        set_cfg(d, 1'b0, err, en, wave, freq, duty);
        if (with_wrap) set_wrap(d, 1'b1);
        idle(1);
        set_wrap(d, 1'b0);
        set_cfg(d, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 16'd0);
    endtask

    task automatic pulse_wrap(input int d);
        set_wrap(d, 1'b1);
        idle(1);
        set_wrap(d, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q2.size() > 0) && n < 64) begin
            idle(1);
            n++;
        end
        check_eq("scoreboard_drained", 64'(q0.size() + q2.size()), 64'd0);
    endtask

    logic [63:0] ramp_up[8];
    logic [63:0] ramp_down[5];
    int c0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // 0 -> 16, shift 2: steps 4,3,2,1,1,1,1 then diff 3 >>> 2 = 0 snaps.
        ramp_up = '{64'd4, 64'd7, 64'd9, 64'd10, 64'd11, 64'd12, 64'd13, 64'd16};
        // 7 -> 0, shift 2: -7>>>2=-2, -5>>>2=-2, -3>>>2=-1, -2>>>2=-1, -1>>>2=-1.
        ramp_down = '{64'd5, 64'd3, 64'd2, 64'd1, 64'd0};
        pw0 = 1'b0;
        pw2 = 1'b0;
        set_cfg(0, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 16'd0);
        set_cfg(2, 1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 16'd0);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // Reset state with no stimulus.
        push_exp(0, cyc, 0, 2'd0, 64'd0, 16'h8000, 0, 0, 0);
        push_exp(2, cyc, 0, 2'd0, 64'd0, 16'h8000, 0, 0, 0);

        // Direct jump on the first wrap.
        capture(0, 1'b0, 1'b1, 2'd2, 64'd1000, 16'h4000, 1'b0);
        push_exp(0, cyc, 0, 2'd0, 64'd0, 16'h8000, 0, 1, 0);
        idle(1);
        push_exp(0, cyc + 1, 1, 2'd2, 64'd1000, 16'h4000, 1, 0, 0);
        push_exp(0, cyc + 2, 1, 2'd2, 64'd1000, 16'h4000, 0, 0, 0);
        pulse_wrap(0);
        idle(2);

        // Errored transaction is discarded.
        capture(0, 1'b1, 1'b0, 2'd1, 64'd77, 16'h0001, 1'b0);
        push_exp(0, cyc, 1, 2'd2, 64'd1000, 16'h4000, 0, 0, 0);
        push_exp(0, cyc + 3, 1, 2'd2, 64'd1000, 16'h4000, 0, 0, 0);
        idle(4);

        // Capture while ARMED, second capture coinciding with a wrap.
        capture(0, 1'b0, 1'b1, 2'd3, 64'd2000, 16'h1111, 1'b0);
        push_exp(0, cyc, 1, 2'd2, 64'd1000, 16'h4000, 0, 1, 0);
        capture(0, 1'b0, 1'b0, 2'd1, 64'd3000, 16'h2222, 1'b1);
        push_exp(0, cyc, 1, 2'd2, 64'd1000, 16'h4000, 0, 1, 0);
        idle(1);
        push_exp(0, cyc + 1, 0, 2'd1, 64'd3000, 16'h2222, 1, 0, 0);
        pulse_wrap(0);
        idle(2);

        // No wraps: synthetic tick 8 clocks after entering ARMED.
        capture(0, 1'b0, 1'b1, 2'd0, 64'd5, 16'h3333, 1'b0);
        c0 = cyc;
        push_exp(0, c0,      0, 2'd1, 64'd3000, 16'h2222, 0, 1, 0);
        push_exp(0, c0 + 7,  0, 2'd1, 64'd3000, 16'h2222, 0, 1, 0);
        push_exp(0, c0 + 8,  1, 2'd0, 64'd5,    16'h3333, 1, 0, 1);
        push_exp(0, c0 + 9,  1, 2'd0, 64'd5,    16'h3333, 0, 0, 1);
        push_exp(0, c0 + 15, 1, 2'd0, 64'd5,    16'h3333, 0, 0, 1);
        idle(16);
        capture(0, 1'b0, 1'b1, 2'd0, 64'd6, 16'h3333, 1'b0);
        push_exp(0, cyc, 1, 2'd0, 64'd5, 16'h3333, 0, 1, 0);
        idle(1);
        push_exp(0, cyc + 1, 1, 2'd0, 64'd6, 16'h3333, 1, 0, 0);
        pulse_wrap(0);
        drain();

        // Geometric glide 0 -> 16.
        capture(2, 1'b0, 1'b1, 2'd1, 64'd16, 16'h1000, 1'b0);
        push_exp(2, cyc, 0, 2'd0, 64'd0, 16'h8000, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            idle(2);
            push_exp(2, cyc + 1, 1, 2'd1, ramp_up[i], 16'h1000, (i == 7), (i != 7), 0);
            pulse_wrap(2);
        end
        drain();

        // Start a downward glide, then reset asynchronously mid-ramp.
        capture(2, 1'b0, 1'b0, 2'd0, 64'd0, 16'h1234, 1'b0);
        idle(1);
        push_exp(2, cyc + 1, 0, 2'd0, 64'd12, 16'h1234, 0, 1, 0);
        pulse_wrap(2);
        idle(1);
        push_exp(2, cyc + 1, 0, 2'd0, 64'd9, 16'h1234, 0, 1, 0);
        pulse_wrap(2);
        drain();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_reset.freq", freq2, 64'd0);
        check_eq("async_reset.enable", 64'(en2), 64'd0);
        check_eq("async_reset.duty", 64'(duty2), 64'h8000);
        check_eq("async_reset.sched_busy", 64'(busy2), 64'd0);
        check_eq("async_reset.dut0_freq", freq0, 64'd0);
        idle(1);
        reset_n = 1'b1;
        idle(1);

        // Redirect to 0 while gliding up (at 7): continues downward from 7.
        capture(2, 1'b0, 1'b1, 2'd2, 64'd16, 16'h5000, 1'b0);
        push_exp(2, cyc, 0, 2'd0, 64'd0, 16'h8000, 0, 1, 0);
        for (int i = 0; i < 2; i++) begin
            idle(1);
            push_exp(2, cyc + 1, 1, 2'd2, ramp_up[i], 16'h5000, 0, 1, 0);
            pulse_wrap(2);
        end
        capture(2, 1'b0, 1'b0, 2'd3, 64'd0, 16'h6000, 1'b0);
        push_exp(2, cyc, 1, 2'd2, 64'd7, 16'h5000, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            push_exp(2, cyc + 1, 0, 2'd3, ramp_down[i], 16'h6000, (i == 4), (i != 4), 0);
            pulse_wrap(2);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
